motor_ramp_sequencer: RTL

MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

---
 rtl/motor_ramp_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/motor_ramp_sequencer.sv
// Purpose : steps a PWM motor driver select code between speed levels, with a dead time before reversal and an emergency stop.
// Latency : first psw change STEP_CYCLES edges after acceptance; a reversal adds a DEAD_CYCLES dead time at psw 000.
// Backpress: req_ready is high only in IDLE/HOLD with estop low; commands offered at any other time wait (are not taken).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    command handshake; req_level (0..3) and req_dir (0 fwd, 1 rev) are taken on acceptance
//   estop                  synchronous, level-sensitive emergency stop (highest priority)
//   psw                    registered select code to the PWM driver (never 3'b111)
//   busy, state_o          status: busy outside IDLE/HOLD, state encoding IDLE=0 RAMP_UP=1 RAMP_DOWN=2 DEAD=3 HOLD=4
module motor_ramp_sequencer #(
    parameter logic [15:0] STEP_CYCLES = 16'd1000,
    parameter logic [15:0] DEAD_CYCLES = 16'd500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_level,
    input  logic       req_dir,
    output logic       req_ready,
    input  logic       estop,
    output logic [2:0] psw,
    output logic       busy,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RAMP_DOWN = 3'd2,
        S_DEAD      = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cur_level_q, cur_level_d;
    logic        cur_dir_q, cur_dir_d;
    logic [1:0]  tgt_level_q, tgt_level_d;
    logic        tgt_dir_q, tgt_dir_d;
    logic [15:0] tmr_q, tmr_d;
    logic [2:0]  psw_q, psw_d;
    logic        rdy_en_q, rdy_en_d;

    logic        accept;
    logic        settled;
    logic [1:0]  lvl_nxt;

    // Reverse levels are shifted down by one so the top reverse speed is 110, never 111.
    function automatic logic [2:0] psw_code(input logic [1:0] lvl, input logic dir);
        logic [2:0] code;
        if (lvl == 2'd0) begin
            code = 3'b000;
        end else if (!dir) begin
            code = {1'b0, lvl};
        end else begin
            code = {1'b1, lvl - 2'd1};
        end
        return code;
    endfunction

    assign settled   = (state_q == S_IDLE) || (state_q == S_HOLD);
    // rdy_en_q keeps req_ready low during reset and until the first edge after release.
    assign req_ready = rdy_en_q && settled && !estop;
    assign accept    = req_valid && req_ready;
    assign busy      = !settled;
    assign state_o   = state_q;
    assign psw       = psw_q;

    always_comb begin
        state_d     = state_q;
        cur_level_d = cur_level_q;
        cur_dir_d   = cur_dir_q;
        tgt_level_d = tgt_level_q;
        tgt_dir_d   = tgt_dir_q;
        tmr_d       = (tmr_q != 16'd0) ? tmr_q - 16'd1 : 16'd0;
        rdy_en_d    = 1'b1;
        lvl_nxt     = cur_level_q;

        if (estop) begin
            // Reloading every cycle makes the dead time count from the last estop-high edge.
            cur_level_d = 2'd0;
            tgt_level_d = 2'd0;
            state_d     = S_DEAD;
            tmr_d       = DEAD_CYCLES - 16'd1;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        tgt_level_d = req_level;
                        tgt_dir_d   = req_dir;
                        if ((req_level == cur_level_q && req_dir == cur_dir_q) ||
                            (req_level == 2'd0 && cur_level_q == 2'd0)) begin
                            state_d = (cur_level_q == 2'd0) ? S_IDLE : S_HOLD;
                        end else if (req_dir != cur_dir_q) begin
                            // Reversal: spin down first; from standstill go straight to the dead time.
                            if (cur_level_q != 2'd0) begin
                                state_d = S_RAMP_DOWN;
                                tmr_d   = STEP_CYCLES - 16'd1;
                            end else begin
                                state_d = S_DEAD;
                                tmr_d   = DEAD_CYCLES - 16'd1;
                            end
                        end else if (req_level > cur_level_q) begin
                            state_d = S_RAMP_UP;
                            tmr_d   = STEP_CYCLES - 16'd1;
                        end else begin
                            state_d = S_RAMP_DOWN;
                            tmr_d   = STEP_CYCLES - 16'd1;
                        end
                    end
                end

                S_RAMP_UP: begin
                    if (tmr_q == 16'd0) begin
                        tmr_d       = STEP_CYCLES - 16'd1;
                        lvl_nxt     = (cur_level_q != 2'd3) ? cur_level_q + 2'd1 : cur_level_q;
                        cur_level_d = lvl_nxt;
                        if (lvl_nxt >= tgt_level_q) begin
                            state_d = S_HOLD;
                        end
                    end
                end

                S_RAMP_DOWN: begin
                    if (tmr_q == 16'd0) begin
                        tmr_d       = STEP_CYCLES - 16'd1;
                        lvl_nxt     = (cur_level_q != 2'd0) ? cur_level_q - 2'd1 : cur_level_q;
                        cur_level_d = lvl_nxt;
                        if (tgt_dir_q != cur_dir_q) begin
                            if (lvl_nxt == 2'd0) begin
                                state_d = S_DEAD;
                                tmr_d   = DEAD_CYCLES - 16'd1;
                            end
                        end else if (lvl_nxt <= tgt_level_q) begin
                            state_d = (lvl_nxt == 2'd0) ? S_IDLE : S_HOLD;
                        end
                    end
                end

                S_DEAD: begin
                    if (tmr_q == 16'd0) begin
                        cur_dir_d = tgt_dir_q;
                        if (tgt_level_q != 2'd0) begin
                            state_d = S_RAMP_UP;
                            tmr_d   = STEP_CYCLES - 16'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    cur_level_d = 2'd0;
                end
            endcase
        end

        psw_d = psw_code(cur_level_d, cur_dir_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_level_q <= 2'd0;
            cur_dir_q   <= 1'b0;
            tgt_level_q <= 2'd0;
            tgt_dir_q   <= 1'b0;
            tmr_q       <= 16'd0;
            psw_q       <= 3'b000;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_level_q <= cur_level_d;
            cur_dir_q   <= cur_dir_d;
            tgt_level_q <= tgt_level_d;
            tgt_dir_q   <= tgt_dir_d;
            tmr_q       <= tmr_d;
            psw_q       <= psw_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule
